approx_seq_mult: RTL and testbench



---
 rtl/approx_mult_pkg.sv | 28 ++
 rtl/mult_pp_row.sv | 13 +
 rtl/approx_seq_mult.sv | 95 +++++++++
 tb/tb_approx_seq_mult.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate sequential multiplier.
// col_mask builds the column-keep mask used to drop low partial-product bits.
package approx_mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int unsigned MAX_PW = 128;

    function automatic int calc_n(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int calc_tw(input int width);
        return $clog2(2 * width + 1);
    endfunction

    // Bit k is kept iff k >= trunc; columns at or above width are always zero.
    function automatic logic [MAX_PW-1:0] col_mask(input int unsigned trunc,
                                                   input int unsigned width);
        logic [MAX_PW-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < MAX_PW; k++) begin
            m[k] = (k < width) && (k >= trunc);
        end
        return m;
    endfunction

endpackage

// File: rtl/mult_pp_row.sv
// Combinational WIDTH x DIGIT unsigned row product for one multiplier digit.
module mult_pp_row #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [DIGIT-1:0]       d,
    output logic [WIDTH+DIGIT-1:0] row
);

    assign row = {{DIGIT{1'b0}}, a} * {{WIDTH{1'b0}}, d};

endmodule

// File: rtl/approx_seq_mult.sv
// Digit-serial shift-add multiplier with run-time truncation of low columns.
// Operands and trunc are captured at acceptance; one digit row is summed per RUN cycle.
module approx_seq_mult
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    parameter int TW    = calc_tw(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [TW-1:0]      trunc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int N  = calc_n(WIDTH, DIGIT);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [TW-1:0]        trunc_q;
    logic [PW-1:0]        acc_q;
    logic [CW-1:0]        cnt_q;

    logic [DIGIT-1:0]       digit;
    logic [WIDTH+DIGIT-1:0] row;
    logic [PW-1:0]          row_ext, row_masked, mask;

    assign digit = b_q[DIGIT*cnt_q +: DIGIT];

    mult_pp_row #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_row (
        .a   (a_q),
        .d   (digit),
        .row (row)
    );

    // Shift the row into its column position, then drop the truncated columns.
    assign row_ext    = PW'(row) << (DIGIT * cnt_q);
    assign mask       = PW'(col_mask(32'(trunc_q), PW));
    assign row_masked = row_ext & mask;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = RUN;
            RUN:  if (cnt_q == CW'(N - 1)) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            trunc_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        trunc_q <= trunc;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    acc_q <= acc_q + row_masked;
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // in_ready is held low during reset so nothing is offered acceptance then.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = acc_q;

endmodule

// File: tb/tb_approx_seq_mult.sv
// Scoreboard bench for approx_seq_mult at WIDTH=16, DIGIT=4.
// Expected products are queued at acceptance and popped at each output transfer.
module tb_approx_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [5:0]  trunc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] product;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    approx_seq_mult #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .trunc     (trunc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_prod(input logic [15:0] av, input logic [15:0] bv,
                                             input logic [5:0] tv);
        logic [63:0] acc;
        logic [31:0] m;
        logic [3:0]  dg;
        acc = '0;
        m   = '0;
        for (int k = 0; k < 32; k++) m[k] = (k >= int'(tv));
        for (int i = 0; i < 4; i++) begin
            dg  = bv[4*i +: 4];
            acc = acc + (((64'(av) * 64'(dg)) << (4*i)) & {32'h0, m});
        end
        return acc[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand set; returns after the acceptance edge with inputs scrambled.
    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [5:0] tv,
                        output int ok);
        ok = 0;
        a = av; b = bv; trunc = tv; in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (in_ready) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (ok != 0) begin
            exp_q.push_back(ref_prod(av, bv, tv));
            tick();
        end
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); trunc = 6'($urandom);
    endtask

    // Wait for an output transfer; lat is ticks from the accept edge to first out_valid.
    task automatic receive(input int rnd, output logic [31:0] got, output logic [31:0] expv,
                           output int lat, output int ok);
        ok = 0;
        lat = -1;
        for (int c = 0; c < 100; c++) begin
            if (rnd != 0) out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && lat < 0) lat = c;
            if (out_valid && out_ready) begin
                ok = 1;
                break;
            end
            tick();
        end
        got  = product;
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (ok != 0) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        vectors++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got %b want 000", {out_valid, busy, in_ready});
        end
        vectors++;
        if (product !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_product got %h want 00000000", product);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_exact();
        int ok, lat;
        logic [31:0] got, expv;
        out_ready = 1'b1;
        send(16'hFFFF, 16'hFFFF, 6'd0, ok);
        receive(0, got, expv, lat, ok);
        vectors++;
        if (got !== 32'hFFFE0001 || ok == 0) begin
            miscompares++;
            $display("[TB] FAIL exact_product got %h want fffe0001", got);
        end
        vectors++;
        if (lat + 1 !== 5) begin
            miscompares++;
            $display("[TB] FAIL exact_latency got %0d want 5", lat + 1);
        end
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL exact_after got valid/ready %b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_truncation();
        int ok, lat;
        logic [31:0] got, expv;
        logic [5:0]  tv [4] = '{6'd8, 6'd0, 6'd32, 6'd63};
        logic [15:0] av [4] = '{16'h00FF, 16'h00FF, 16'hFFFF, 16'hFFFF};
        logic [31:0] want [4] = '{32'h0000FD00, 32'h0000FE01, 32'h0, 32'h0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(av[i], av[i], tv[i], ok);
            receive(0, got, expv, lat, ok);
            vectors++;
            if (got !== want[i] || ok == 0) begin
                miscompares++;
                $display("[TB] FAIL trunc_%0d got %h want %h", tv[i], got, want[i]);
            end
        end
        send(16'h0000, 16'h1234, 6'd0, ok);
        receive(0, got, expv, lat, ok);
        vectors++;
        if (got !== 32'h0 || ok == 0) begin
            miscompares++;
            $display("[TB] FAIL zero_operand got %h want 00000000", got);
        end
    endtask

    task automatic test_backpressure();
        int ok, lat, seen;
        logic [31:0] got, expv;
        out_ready = 1'b0;
        send(16'h1234, 16'h5678, 6'd4, ok);
        expv = exp_q.pop_front();
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            tick();
        end
        vectors++;
        if (seen == 0) begin
            miscompares++;
            $display("[TB] FAIL bp_timeout got no out_valid want out_valid");
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            a = 16'hAAAA; b = 16'h5555;
            vectors++;
            if (product !== expv || {out_valid, in_ready} !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL bp_hold got %h/%b want %h/10", product, {out_valid, in_ready}, expv);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL bp_release got %b want 01", {out_valid, in_ready});
        end
        send(16'd7, 16'd9, 6'd0, ok);
        receive(0, got, expv, lat, ok);
        vectors++;
        if (got !== 32'd63 || ok == 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL bp_next got %h want 0000003f", got);
        end
    endtask

    task automatic test_reset_mid_op();
        int ok, lat, bad;
        logic [31:0] got, expv;
        out_ready = 1'b1;
        send(16'hFFFF, 16'hFFFF, 6'd0, ok);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        vectors++;
        if ({out_valid, busy} !== 2'b00 || product !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset got %b/%h want 00/00000000", {out_valid, busy}, product);
        end
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) bad = 1;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_spurious got out_valid=1 want 0");
        end
        send(16'd3, 16'd5, 6'd0, ok);
        receive(0, got, expv, lat, ok);
        vectors++;
        if (got !== 32'd15 || ok == 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_next got %h want 0000000f", got);
        end
    endtask

    task automatic test_random();
        int ok, lat, bad;
        logic [31:0] got, expv;
        bad = 0;
        for (int n = 0; n < 4000; n++) begin
            send(16'($urandom), 16'($urandom), 6'($urandom_range(0, 63)), ok);
            receive(1, got, expv, lat, ok);
            vectors++;
            if (got !== expv || ok == 0) begin
                miscompares++;
                if (bad < 10)
                    $display("[TB] FAIL random_%0d got %h want %h", n, got, expv);
                bad++;
            end
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_exact();
        test_truncation();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
